named_block_rr_arbiter: RTL and testbench
=========================================

// Module: named_block_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 8-bit capture path among 4 requesters.
//  Each grant holds the path for up to HOLD cycles and copies the winner's data
//  into that requester's slot register (out1..out4) and a shared out_data register.
//  Per-requester slot state lives in named generate blocks; out1..out4 read it back
//  by hierarchical name. Frontend regression block exercising named-scope elaboration
//  with real sequential logic.
// PARAMETERS
//  NREQ   4   number of requesters; fixed at 4 (out1..out4), other values rejected
//  WIDTH  8   data width per requester
//  HOLD   2   max grant length in cycles; legal range 1..15
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous, active-high reset
//  req       in   4        request per requester, level-sensitive
//  data_in   in   32       packed data; requester i on [8*i+7:8*i]
//  grant     out  4        one-hot grant, registered; 0 when idle
//  valid     out  1        registered pulse, 1 cycle after each capture edge
//  out_data  out  8        last captured data, any requester
//  out_sel   out  2        index of requester that produced out_data
//  out1..4   out  8 each   last captured data of requester 0..3 (slot regs)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, ptr=0, cnt=0, grant=0, valid=0,
//    out_data=0, out_sel=0, out1..out4=0. Reset mid-grant drops grant in the same cycle.
//  - State IDLE, grant=0: if req!=0, winner = first set bit searching ptr, ptr+1, ...
//    modulo 4. Next edge: state=BUSY, grant=onehot(winner), cnt=HOLD-1.
//    If req==0, stay IDLE.
//  - State BUSY, grant[w]=1. Capture edge = any edge with req[w]=1:
//    slot[w] <= data_in[w]; out_data <= data_in[w]; out_sel <= w; valid <= 1.
//    Non-capture edges: valid <= 0.
//  - BUSY release: at an edge where cnt==0 OR req[w]==0:
//    state <= IDLE; grant <= 0; ptr <= (w+1) mod 4.
//    Otherwise cnt <= cnt-1 and grant holds.
//  - Capture and release on the same edge: both happen (data captured, then released).
//  - req[w] low while granted: no capture on that edge; release on that edge.
//  - Latency: req rises at edge k (IDLE) -> grant at k+1 -> first capture at
//    edge k+2 -> valid high in cycle after k+2.
//  - A full HOLD-length grant gives exactly HOLD captures.
//  - Back-to-back: BUSY -> IDLE -> BUSY always; one dead cycle (grant=0) between
//    grants, even when requests are continuously asserted.
//  - Requests from non-winners during BUSY are ignored; not queued, only sampled in IDLE.
//  - ptr wraps 3 -> 0. No starvation: any held req is granted within 4 grants.
//  - Slot i changes only on a capture for requester i. Other slots hold.
//  - cnt width $clog2(HOLD+1).
//  - No combinational path from inputs to outputs.
// TESTING
//  1. Assert rst mid-sim with random req -> all outputs 0 asynchronously,
//     before the next clk edge.
//  2. HOLD=2, req=4'b0001, data0=8'h11 held ->
//     grant=0001 for 2 cycles, 2 valid pulses, out1=8'h11, out_sel=0,
//     then 1 idle cycle, then re-grant 0001.
//  3. req=4'b1111 held, data_i=8'hA0+i ->
//     grant sequence 0001,0010,0100,1000,0001 with an idle cycle between grants;
//     out1..out4 = A0,A1,A2,A3.
//  4. req=4'b0100 then req[2] drops after first capture ->
//     exactly 1 valid pulse, out3 captured once, grant released on the drop edge,
//     ptr=3.
//  5. ptr=3 (after serving req 2), req=4'b1001 ->
//     grant 1000 first, then 0001 (wrap-around).
//  6. HOLD=1, req=4'b0011 ->
//     each grant lasts 1 cycle with 1 capture;
//     alternating 0001/0010 with 1 idle cycle between grants.

Source files
------------

// File: rtl/named_block_rr_arbiter.sv
// Round-robin arbiter that shares one capture path among four requesters.
// Each requester's captured data lives in a named generate scope and is read back by hierarchical name.
module named_block_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic                  valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [1:0]            out_sel,
    output logic [WIDTH-1:0]      out1,
    output logic [WIDTH-1:0]      out2,
    output logic [WIDTH-1:0]      out3,
    output logic [WIDTH-1:0]      out4,
    output logic                  dbg_busy,
    output logic [1:0]            dbg_ptr
);

    localparam int CW = $clog2(HOLD + 1);

    if (NREQ != 4) begin : g_bad_nreq
        $error("named_block_rr_arbiter: NREQ must be 4");
    end
    if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
        $error("named_block_rr_arbiter: HOLD must be in 1..15");
    end

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        gidx_q, gidx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [1:0]        out_sel_q, out_sel_d;
    logic [NREQ-1:0]   cap_vec;
    logic              win_found;
    logic [1:0]        win_idx;
    logic [1:0]        scan_idx;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        valid_d    = 1'b0;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        cap_vec    = '0;
        win_found  = 1'b0;
        win_idx    = ptr_q;
        scan_idx   = ptr_q;

        // Rotating priority scan: the 2-bit add wraps naturally modulo 4.
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    grant_d = NREQ'(1) << win_idx;
                    gidx_d  = win_idx;
                    cnt_d   = CW'(HOLD - 1);
                end
            end
            BUSY: begin
                if (req[gidx_q]) begin
                    cap_vec[gidx_q] = 1'b1;
                    out_data_d      = data_in[gidx_q*WIDTH +: WIDTH];
                    out_sel_d       = gidx_q;
                    valid_d         = 1'b1;
                end
                // A dropped request ends the grant even if hold cycles remain.
                if (cnt_q == '0 || !req[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            out_data_q <= '0;
            out_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        logic [WIDTH-1:0] slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (cap_vec[i]) slot_d = data_in[i*WIDTH +: WIDTH];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) slot_q <= '0;
            else     slot_q <= slot_d;
        end
    end

    assign out1     = g_slot[0].slot_q;
    assign out2     = g_slot[1].slot_q;
    assign out3     = g_slot[2].slot_q;
    assign out4     = g_slot[3].slot_q;
    assign grant    = grant_q;
    assign valid    = valid_q;
    assign out_data = out_data_q;
    assign out_sel  = out_sel_q;
    assign dbg_busy = (state_q == BUSY);
    assign dbg_ptr  = ptr_q;

endmodule

// File: tb/tb_named_block_rr_arbiter.sv
// Directed bench for named_block_rr_arbiter: one instance with HOLD=2, one with HOLD=1.
module tb_named_block_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req2, req1;
    logic [31:0] data_in;

    logic [3:0]  g2, g1;
    logic        v2, v1;
    logic [7:0]  od2, od1;
    logic [1:0]  os2, os1;
    logic [7:0]  a1, a2, a3, a4;
    logic [7:0]  b1, b2, b3, b4;
    logic        busy2, busy1;
    logic [1:0]  ptr2, ptr1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    named_block_rr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .data_in(data_in),
        .grant(g2), .valid(v2), .out_data(od2), .out_sel(os2),
        .out1(a1), .out2(a2), .out3(a3), .out4(a4),
        .dbg_busy(busy2), .dbg_ptr(ptr2)
    );

    named_block_rr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .data_in(data_in),
        .grant(g1), .valid(v1), .out_data(od1), .out_sel(os1),
        .out1(b1), .out2(b2), .out3(b3), .out4(b4),
        .dbg_busy(busy1), .dbg_ptr(ptr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t3_grant [13];
    logic [3:0] t6_grant [6];
    logic       t6_valid [6];

    initial begin
        t3_grant = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                     4'h8, 4'h8, 4'h0, 4'h1};
        t6_grant = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0};
        t6_valid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; req2 = '0; req1 = '0; data_in = '0;
        tick();
        tick();
        check("reset_grant", 32'(g2), 32'h0);
        check("reset_valid", 32'(v2), 32'h0);
        check("reset_slots", {a4, a3, a2, a1}, 32'h0);
        check("reset_ptr", 32'(ptr2), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single requester, HOLD=2: two captures, dead cycle, re-grant.
        req2 = 4'b0001; data_in = 32'hA3A2A111;
        tick();
        check("t2_grant_e1", 32'(g2), 32'h1);
        check("t2_valid_e1", 32'(v2), 32'h0);
        tick();
        check("t2_grant_e2", 32'(g2), 32'h1);
        check("t2_valid_e2", 32'(v2), 32'h1);
        check("t2_out1", 32'(a1), 32'h11);
        check("t2_out_sel", 32'(os2), 32'h0);
        tick();
        check("t2_grant_e3", 32'(g2), 32'h0);
        check("t2_valid_e3", 32'(v2), 32'h1);
        tick();
        check("t2_regrant", 32'(g2), 32'h1);
        check("t2_valid_e4", 32'(v2), 32'h0);

        // Asynchronous reset mid-grant with random requests.
        req2 = 4'($urandom_range(1, 15));
        req1 = 4'($urandom_range(1, 15));
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t1_grant", 32'(g2), 32'h0);
        check("t1_valid", 32'(v2), 32'h0);
        check("t1_out_data", 32'(od2), 32'h0);
        check("t1_out_sel", 32'(os2), 32'h0);
        check("t1_slots", {a4, a3, a2, a1}, 32'h0);
        check("t1_grant_h1", 32'(g1), 32'h0);
        @(negedge clk);
        rst = 1'b0; req2 = '0; req1 = '0;
        tick();

        // All four requesting: rotation with a dead cycle between grants.
        data_in = 32'hA3A2A1A0; req2 = 4'hF;
        for (int i = 0; i < 13; i++) begin
            tick();
            check($sformatf("t3_grant_%0d", i), 32'(g2), 32'(t3_grant[i]));
            check($sformatf("t3_valid_%0d", i), 32'(v2), (i % 3 == 0) ? 32'h0 : 32'h1);
        end
        check("t3_slots", {a4, a3, a2, a1}, 32'hA3A2A1A0);
        check("t3_out_data", 32'(od2), 32'hA3);
        check("t3_out_sel", 32'(os2), 32'h3);
        req2 = '0;
        tick();
        check("t3_ptr", 32'(ptr2), 32'h1);

        // Requester 2 drops after its first capture.
        req2 = 4'b0100; data_in = 32'hA3_5C_A1_A0;
        tick();
        check("t4_grant_e1", 32'(g2), 32'h4);
        check("t4_valid_e1", 32'(v2), 32'h0);
        tick();
        check("t4_valid_e2", 32'(v2), 32'h1);
        check("t4_out3", 32'(a3), 32'h5C);
        req2 = '0; data_in = 32'hA3_77_A1_A0;
        tick();
        check("t4_grant_drop", 32'(g2), 32'h0);
        check("t4_valid_e3", 32'(v2), 32'h0);
        check("t4_out3_hold", 32'(a3), 32'h5C);
        check("t4_ptr", 32'(ptr2), 32'h3);
        tick();
        check("t4_valid_e4", 32'(v2), 32'h0);

        // Wrap-around from ptr=3.
        req2 = 4'b1001; data_in = 32'hD3_77_A1_A0;
        tick();
        check("t5_grant_first", 32'(g2), 32'h8);
        tick();
        check("t5_out4", 32'(a4), 32'hD3);
        tick();
        check("t5_gap", 32'(g2), 32'h0);
        tick();
        check("t5_grant_wrap", 32'(g2), 32'h1);
        req2 = '0;
        tick();
        check("t5_ptr", 32'(ptr2), 32'h1);

        // HOLD=1 instance: one-cycle grants alternating 0001/0010.
        data_in = 32'h44332211; req1 = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t6_grant_%0d", i), 32'(g1), 32'(t6_grant[i]));
            check($sformatf("t6_valid_%0d", i), 32'(v1), 32'(t6_valid[i]));
        end
        check("t6_out1", 32'(b1), 32'h11);
        check("t6_out2", 32'(b2), 32'h22);
        check("t6_out34", {b4, b3}, 32'h0);
        check("t6_out_sel", 32'(os1), 32'h0);
        req1 = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
